div_iter: RTL and testbench

- Parametrised iterative radix-2 integer divider for the EX stage. Handles signed and unsigned operands of any width with one shared datapath.
- Uses a valid/ready handshake on both input and output, so the pipeline can stall on either side.
- Adds a cancel input for pipeline flush and defined divide-by-zero results.
- Quotient and remainder stay held until the consumer accepts them.

---
 rtl/div_iter_if.sv | 27 ++
 rtl/div_iter.sv | 124 ++++++++++++
 tb/tb_div_iter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// Request/response bundle for div_iter: valid/ready on the operand and result sides
// plus a flush (cancel) input. The master drives operands, the slave returns s/r/dbz.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             div_signed;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cancel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             dbz;

    modport master (
        output in_valid, div_signed, x, y, cancel, out_ready,
        input  in_ready, out_valid, s, r, dbz
    );

    modport slave (
        input  in_valid, div_signed, x, y, cancel, out_ready,
        output in_ready, out_valid, s, r, dbz
    );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider: divides operand magnitudes over WIDTH cycles,
// then applies sign fix-up and divide-by-zero substitution before presenting the result.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic       div_clk,
    input  logic       resetn,
    div_iter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_sgn;
    logic [WIDTH-1:0] r_ymag;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_dbz_p;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;

    logic             w_accept;
    logic             w_xneg;
    logic             w_yneg;
    logic [WIDTH-1:0] w_xmag;
    logic [WIDTH-1:0] w_ymag;
    logic [WIDTH:0]   w_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;

    assign w_accept = bus.in_valid & (r_state == S_IDLE) & ~bus.cancel;
    assign w_xneg   = r_sgn & r_x[WIDTH-1];
    assign w_yneg   = r_sgn & r_y[WIDTH-1];
    assign w_xmag   = w_xneg ? -r_x : r_x;
    assign w_ymag   = w_yneg ? -r_y : r_y;

    // Remainder stays below |y|, so the shifted value is < 2*|y| and the
    // difference always fits back into WIDTH bits.
    assign w_sh       = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_sh >= {1'b0, r_ymag});
    assign w_rem_next = w_ge ? (w_sh[WIDTH-1:0] - r_ymag) : w_sh[WIDTH-1:0];

    always_ff @(posedge div_clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_PREP;
            S_PREP: w_next = bus.cancel ? S_IDLE : S_ITER;
            S_ITER: begin
                if (bus.cancel)        w_next = S_IDLE;
                else if (r_cnt == '0)  w_next = S_FIX;
            end
            S_FIX:  w_next = bus.cancel ? S_IDLE : S_DONE;
            S_DONE: if (bus.cancel || bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge div_clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_sgn   <= 1'b0;
            r_ymag  <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_dbz_p <= 1'b0;
            r_s     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x   <= bus.x;
                r_y   <= bus.y;
                r_sgn <= bus.div_signed;
            end
            unique case (r_state)
                S_PREP: begin
                    r_quo   <= w_xmag;
                    r_ymag  <= w_ymag;
                    r_rem   <= '0;
                    r_qneg  <= r_sgn & (r_x[WIDTH-1] ^ r_y[WIDTH-1]);
                    r_rneg  <= w_xneg;
                    r_dbz_p <= (r_y == '0);
                    r_cnt   <= CW'(WIDTH - 1);
                end
                S_ITER: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    if (!bus.cancel) begin
                        r_s   <= r_dbz_p ? '1  : (r_qneg ? -r_quo : r_quo);
                        r_r   <= r_dbz_p ? r_x : (r_rneg ? -r_rem : r_rem);
                        r_dbz <= r_dbz_p;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s   = r_s;
    assign bus.r   = r_r;
    assign bus.dbz = r_dbz;
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed and random divisions on 32- and 8-bit
// instances, compared against native integer division with the divide-by-zero rule.
module tb_div_iter;
    logic div_clk = 1'b0;
    logic resetn  = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    always #5 div_clk = ~div_clk;

    div_iter_if #(.WIDTH(32)) bus32 ();
    div_iter_if #(.WIDTH(8))  bus8 ();

    div_iter #(.WIDTH(32)) u_dut32 (.div_clk(div_clk), .resetn(resetn), .bus(bus32));
    div_iter #(.WIDTH(8))  u_dut8  (.div_clk(div_clk), .resetn(resetn), .bus(bus8));

    localparam logic [31:0] TX  [6] = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'h80000000, 32'h12345678, 32'h12345678};
    localparam logic [31:0] TY  [6] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    localparam logic        TSG [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [31:0] TS  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    localparam logic [31:0] TR  [6] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h80000000, 32'h12345678, 32'h12345678};
    localparam logic        TD  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reference: host integer division (truncating, remainder follows dividend) at width w.
    function automatic void model(input int w, input logic sg, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] es, output logic [63:0] er, output logic ed);
        logic [63:0] mask;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        if ((b & mask) == 64'd0) begin
            es = mask; er = a & mask; ed = 1'b1;
        end else begin
            ed = 1'b0;
            if (sg) begin
                sa = longint'(a << (64 - w)); sa = sa >>> (64 - w);
                sb = longint'(b << (64 - w)); sb = sb >>> (64 - w);
                es = 64'(sa / sb) & mask;
                er = 64'(sa % sb) & mask;
            end else begin
                es = (a & mask) / (b & mask);
                er = (a & mask) % (b & mask);
            end
        end
    endfunction

    task automatic issue32(input logic sg, input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        while (!bus32.in_ready && t < 100) begin @(negedge div_clk); t++; end
        n_vec++;
        if (t >= 100) begin n_err++; $display("FAIL issue32_ready: in_ready=%0b required 1", bus32.in_ready); end
        bus32.in_valid = 1'b1; bus32.div_signed = sg; bus32.x = a; bus32.y = b;
        @(posedge div_clk); @(negedge div_clk);
        bus32.in_valid = 1'b0; bus32.x = $urandom; bus32.y = $urandom; bus32.div_signed = 1'($urandom);
    endtask

    task automatic issue8(input logic sg, input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        while (!bus8.in_ready && t < 100) begin @(negedge div_clk); t++; end
        n_vec++;
        if (t >= 100) begin n_err++; $display("FAIL issue8_ready: in_ready=%0b required 1", bus8.in_ready); end
        bus8.in_valid = 1'b1; bus8.div_signed = sg; bus8.x = a; bus8.y = b;
        @(posedge div_clk); @(negedge div_clk);
        bus8.in_valid = 1'b0; bus8.x = 8'($urandom); bus8.y = 8'($urandom); bus8.div_signed = 1'($urandom);
    endtask

    task automatic wait32(output int lat);
        lat = 0;
        while (!bus32.out_valid && lat < 200) begin @(negedge div_clk); lat++; end
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (!bus8.out_valid && lat < 200) begin @(negedge div_clk); lat++; end
    endtask

    task automatic retire32;
        bus32.out_ready = 1'b1; @(negedge div_clk); bus32.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        n_vec += 5;
        if (bus32.in_ready !== 1'b1)  begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus32.in_ready); end
        if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus32.out_valid); end
        if (bus32.s !== 32'h0)        begin n_err++; $display("FAIL rst_s: got %h want 0", bus32.s); end
        if (bus32.r !== 32'h0)        begin n_err++; $display("FAIL rst_r: got %h want 0", bus32.r); end
        if (bus32.dbz !== 1'b0)       begin n_err++; $display("FAIL rst_dbz: got %b want 0", bus32.dbz); end
        @(negedge div_clk); resetn = 1'b1; @(negedge div_clk);
    endtask

    task automatic test_unsigned;
        int lat;
        issue32(1'b0, 32'd100, 32'd7);
        wait32(lat);
        n_vec += 4;
        if (lat !== 34)               begin n_err++; $display("FAIL u_latency: got %0d want 34", lat); end
        if (bus32.s !== 32'd14)       begin n_err++; $display("FAIL u_s: got %h want %h", bus32.s, 32'd14); end
        if (bus32.r !== 32'd2)        begin n_err++; $display("FAIL u_r: got %h want %h", bus32.r, 32'd2); end
        if (bus32.dbz !== 1'b0)       begin n_err++; $display("FAIL u_dbz: got %b want 0", bus32.dbz); end
        for (int i = 0; i < 5; i++) begin
            @(negedge div_clk);
            n_vec += 4;
            if (bus32.out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid: got %b want 1", bus32.out_valid); end
            if (bus32.in_ready !== 1'b0)  begin n_err++; $display("FAIL hold_in_ready: got %b want 0", bus32.in_ready); end
            if (bus32.s !== 32'd14)       begin n_err++; $display("FAIL hold_s: got %h want %h", bus32.s, 32'd14); end
            if (bus32.r !== 32'd2)        begin n_err++; $display("FAIL hold_r: got %h want %h", bus32.r, 32'd2); end
        end
        retire32();
        n_vec += 3;
        if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL retire_valid: got %b want 0", bus32.out_valid); end
        if (bus32.in_ready !== 1'b1)  begin n_err++; $display("FAIL retire_in_ready: got %b want 1", bus32.in_ready); end
        if (bus32.s !== 32'd14)       begin n_err++; $display("FAIL retire_hold_s: got %h want %h", bus32.s, 32'd14); end
    endtask

    task automatic test_directed;
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue32(TSG[i], TX[i], TY[i]);
            wait32(lat);
            n_vec += 4;
            if (lat !== 34)          begin n_err++; $display("FAIL dir%0d_latency: got %0d want 34", i, lat); end
            if (bus32.s !== TS[i])   begin n_err++; $display("FAIL dir%0d_s: got %h want %h", i, bus32.s, TS[i]); end
            if (bus32.r !== TR[i])   begin n_err++; $display("FAIL dir%0d_r: got %h want %h", i, bus32.r, TR[i]); end
            if (bus32.dbz !== TD[i]) begin n_err++; $display("FAIL dir%0d_dbz: got %b want %b", i, bus32.dbz, TD[i]); end
            retire32();
        end
    endtask

    task automatic test_random32(input int n);
        int          lat;
        logic        sg, ed;
        logic [31:0] a, b;
        logic [63:0] es, er;
        for (int i = 0; i < n; i++) begin
            sg = 1'($urandom); a = $urandom; b = $urandom;
            if (i % 4 == 1) b = 32'($urandom_range(1, 300));
            if (i % 4 == 2) b = -32'($urandom_range(1, 300));
            if (i % 9 == 0) b = '0;
            model(32, sg, {32'h0, a}, {32'h0, b}, es, er, ed);
            issue32(sg, a, b);
            wait32(lat);
            n_vec += 4;
            if (lat !== 34)            begin n_err++; $display("FAIL rnd32_latency: got %0d want 34", lat); end
            if (bus32.s !== es[31:0])  begin n_err++; $display("FAIL rnd32_s (%0b %h/%h): got %h want %h", sg, a, b, bus32.s, es[31:0]); end
            if (bus32.r !== er[31:0])  begin n_err++; $display("FAIL rnd32_r (%0b %h/%h): got %h want %h", sg, a, b, bus32.r, er[31:0]); end
            if (bus32.dbz !== ed)      begin n_err++; $display("FAIL rnd32_dbz: got %b want %b", bus32.dbz, ed); end
            retire32();
        end
    endtask

    task automatic test_cancel;
        int lat;
        issue32(1'b0, 32'd1000, 32'd3);
        repeat (9) @(negedge div_clk);
        bus32.cancel = 1'b1; @(negedge div_clk); bus32.cancel = 1'b0;
        n_vec += 2;
        if (bus32.in_ready !== 1'b1)  begin n_err++; $display("FAIL cancel_in_ready: got %b want 1", bus32.in_ready); end
        if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL cancel_valid: got %b want 0", bus32.out_valid); end
        issue32(1'b0, 32'd100, 32'd7);
        wait32(lat);
        n_vec += 2;
        if (lat !== 34)         begin n_err++; $display("FAIL cancel_next_latency: got %0d want 34", lat); end
        if (bus32.s !== 32'd14) begin n_err++; $display("FAIL cancel_next_s: got %h want %h", bus32.s, 32'd14); end
        retire32();
        // Cancel while a result is held: result dropped, data registers keep their values.
        issue32(1'b0, 32'd50, 32'd5);
        wait32(lat);
        bus32.cancel = 1'b1; bus32.out_ready = 1'b1; @(negedge div_clk);
        bus32.cancel = 1'b0; bus32.out_ready = 1'b0;
        n_vec += 3;
        if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL cancel_done_valid: got %b want 0", bus32.out_valid); end
        if (bus32.in_ready !== 1'b1)  begin n_err++; $display("FAIL cancel_done_in_ready: got %b want 1", bus32.in_ready); end
        if (bus32.s !== 32'd10)       begin n_err++; $display("FAIL cancel_done_s: got %h want %h", bus32.s, 32'd10); end
        bus32.in_valid = 1'b1; bus32.cancel = 1'b1; bus32.x = 32'd9; bus32.y = 32'd3;
        @(negedge div_clk);
        bus32.in_valid = 1'b0; bus32.cancel = 1'b0;
        n_vec++;
        if (bus32.in_ready !== 1'b1)  begin n_err++; $display("FAIL cancel_idle_accept: in_ready=%b want 1", bus32.in_ready); end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        issue32(1'b1, $urandom, 32'd13);
        repeat (10) @(negedge div_clk);
        #2 resetn = 1'b0;
        #1;
        n_vec += 5;
        if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", bus32.out_valid); end
        if (bus32.in_ready !== 1'b1)  begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 1", bus32.in_ready); end
        if (bus32.s !== 32'h0)        begin n_err++; $display("FAIL mid_rst_s: got %h want 0", bus32.s); end
        if (bus32.r !== 32'h0)        begin n_err++; $display("FAIL mid_rst_r: got %h want 0", bus32.r); end
        if (bus32.dbz !== 1'b0)       begin n_err++; $display("FAIL mid_rst_dbz: got %b want 0", bus32.dbz); end
        @(negedge div_clk); resetn = 1'b1;
        for (int i = 0; i < 40; i++) begin @(negedge div_clk); if (bus32.out_valid) seen++; end
        n_vec++;
        if (seen !== 0) begin n_err++; $display("FAIL mid_rst_no_result: out_valid cycles %0d want 0", seen); end
    endtask

    task automatic test_width8(input int n);
        int          lat;
        logic        sg, ed;
        logic [7:0]  a, b;
        logic [63:0] es, er;
        for (int i = 0; i < n; i++) begin
            sg = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            if (i % 10 == 0) b = '0;
            if (i % 10 == 1) begin a = 8'h80; b = 8'hFF; end
            model(8, sg, {56'h0, a}, {56'h0, b}, es, er, ed);
            issue8(sg, a, b);
            wait8(lat);
            n_vec += 4;
            if (lat !== 10)          begin n_err++; $display("FAIL w8_latency: got %0d want 10", lat); end
            if (bus8.s !== es[7:0])  begin n_err++; $display("FAIL w8_s (%0b %h/%h): got %h want %h", sg, a, b, bus8.s, es[7:0]); end
            if (bus8.r !== er[7:0])  begin n_err++; $display("FAIL w8_r (%0b %h/%h): got %h want %h", sg, a, b, bus8.r, er[7:0]); end
            if (bus8.dbz !== ed)     begin n_err++; $display("FAIL w8_dbz: got %b want %b", bus8.dbz, ed); end
            bus8.out_ready = 1'b1; @(negedge div_clk); bus8.out_ready = 1'b0;
        end
    endtask

    initial begin
        bus32.in_valid = 1'b0; bus32.div_signed = 1'b0; bus32.x = '0; bus32.y = '0;
        bus32.cancel = 1'b0; bus32.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.div_signed = 1'b0; bus8.x = '0; bus8.y = '0;
        bus8.cancel = 1'b0; bus8.out_ready = 1'b0;
        test_reset();
        test_unsigned();
        test_directed();
        test_random32(30);
        test_cancel();
        test_reset_mid();
        test_width8(250);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
